// File: rtl/fetch_pc_if.sv
// Fetch PC unit bus: decoder strobes, operands and PC/statistics outputs.
interface fetch_pc_if;
    logic [31:0] in_instr;
    logic        in_J;
    logic        in_JW;
    logic        in_JR;
    logic        in_BEQ;
    logic        in_BNE;
    logic        in_BGEZ;
    logic        in_syscall;
    logic        in_equal;
    logic [31:0] in_rs;
    logic [31:0] in_v0;
    logic        in_go;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_halted;
    logic [31:0] out_cycles;
    logic [31:0] out_uncond;
    logic [31:0] out_cond;

    modport master (
        output in_instr, in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ,
               in_syscall, in_equal, in_rs, in_v0, in_go,
        input  out_pc, out_pc4, out_halted, out_cycles, out_uncond, out_cond
    );

    modport slave (
        input  in_instr, in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ,
               in_syscall, in_equal, in_rs, in_v0, in_go,
        output out_pc, out_pc4, out_halted, out_cycles, out_uncond, out_cond
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: next-PC selection, RUN/HALT control with operator resume,
// and optional statistics counters (enabled by macro FETCH_STATS_EN).
module fetch_pc_unit (
    input  logic       in_clk,
    input  logic       in_rst,
    fetch_pc_if.slave  bus
);
    localparam int unsigned W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   pc_q;
    logic [W-1:0]   pc_d;
    logic [W-1:0]   pc4;
    logic [W-1:0]   br_off;
    logic [W-1:0]   jmp_tgt;
    logic           go_q;
    logic           go_edge;
    logic           halt_req;
    logic           jump;
    logic           taken;
    logic           unused_instr_hi;

    assign pc4      = pc_q + W'(4);
    assign go_edge  = bus.in_go & ~go_q;
    assign halt_req = bus.in_syscall & (bus.in_v0 == W'(10));
    assign jump     = bus.in_J | bus.in_JW | bus.in_JR;
    assign taken    = (bus.in_BEQ & bus.in_equal) | (bus.in_BNE & ~bus.in_equal)
                    | (bus.in_BGEZ & ~bus.in_rs[31]);
    assign br_off   = {{14{bus.in_instr[15]}}, bus.in_instr[15:0], 2'b00};
    assign jmp_tgt  = {pc4[31:28], bus.in_instr[25:0], 2'b00};
    // Opcode bits are decoded upstream; only immediate/target fields matter here.
    assign unused_instr_hi = ^bus.in_instr[31:26];

    // State, PC and go-history registers.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            go_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            go_q    <= bus.in_go;
        end
    end

    // Next-state and next-PC selection; halt has top priority in RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (bus.in_JR) begin
                    pc_d = bus.in_rs;
                end else if (bus.in_J | bus.in_JW) begin
                    pc_d = jmp_tgt;
                end else if (taken) begin
                    pc_d = pc4 + br_off;
                end else begin
                    pc_d = pc4;
                end
            end
            HALT: begin
                if (go_edge) begin
                    state_d = RUN;
                    pc_d    = pc4;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.out_pc     = pc_q;
    assign bus.out_pc4    = pc4;
    assign bus.out_halted = (state_q == HALT);

`ifdef FETCH_STATS_EN
    logic [W-1:0] cycles_q;
    logic [W-1:0] uncond_q;
    logic [W-1:0] cond_q;

    // Statistics counters; frozen in HALT, wrap naturally at 2^32.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cycles_q <= '0;
            uncond_q <= '0;
            cond_q   <= '0;
        end else if (state_q == RUN) begin
            cycles_q <= cycles_q + W'(1);
            if (jump && !halt_req) begin
                uncond_q <= uncond_q + W'(1);
            end
            if (taken && !jump && !halt_req) begin
                cond_q <= cond_q + W'(1);
            end
        end
    end

    assign bus.out_cycles = cycles_q;
    assign bus.out_uncond = uncond_q;
    assign bus.out_cond   = cond_q;
`else
    assign bus.out_cycles = '0;
    assign bus.out_uncond = '0;
    assign bus.out_cond   = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit; counter expectations
// follow whether FETCH_STATS_EN is defined for the build.
module tb_fetch_pc_unit;
`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Strobe bit positions: {J, JW, JR, BEQ, BNE, BGEZ, SYS}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_J    = 7'b1000000;
    localparam logic [6:0] S_JW   = 7'b0100000;
    localparam logic [6:0] S_JR   = 7'b0010000;
    localparam logic [6:0] S_BEQ  = 7'b0001000;
    localparam logic [6:0] S_BNE  = 7'b0000100;
    localparam logic [6:0] S_BGEZ = 7'b0000010;
    localparam logic [6:0] S_SYS  = 7'b0000001;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [6:0]  stb;
        logic        equal;
        logic [31:0] rs;
        logic [31:0] v0;
        logic        go;
        logic [31:0] pc;
        logic        halt;
        logic [31:0] cyc;
        logic [31:0] unc;
        logic [31:0] cnd;
    } vec_t;

    logic in_clk;
    logic in_rst;
    int   checks;
    int   failures;
    vec_t vecs[$];

    fetch_pc_if bus ();

    fetch_pc_unit dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [31:0] instr, input logic [6:0] stb,
                       input logic equal, input logic [31:0] rs, input logic [31:0] v0,
                       input logic go, input logic [31:0] pc, input logic halt,
                       input logic [31:0] cyc, input logic [31:0] unc, input logic [31:0] cnd);
        vec_t v;
        v = '{rst, instr, stb, equal, rs, v0, go, pc, halt, cyc, unc, cnd};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        in_rst         = v.rst;
        bus.in_instr   = v.instr;
        bus.in_J       = v.stb[6];
        bus.in_JW      = v.stb[5];
        bus.in_JR      = v.stb[4];
        bus.in_BEQ     = v.stb[3];
        bus.in_BNE     = v.stb[2];
        bus.in_BGEZ    = v.stb[1];
        bus.in_syscall = v.stb[0];
        bus.in_equal   = v.equal;
        bus.in_rs      = v.rs;
        bus.in_v0      = v.v0;
        bus.in_go      = v.go;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic halt,
                               input logic [31:0] cyc, input logic [31:0] unc,
                               input logic [31:0] cnd);
        logic [31:0] pc4_exp;
        pc4_exp = pc + 32'd4;
        chk({tag, ".pc"}, bus.out_pc, pc);
        chk({tag, ".pc4"}, bus.out_pc4, pc4_exp);
        chk({tag, ".halted"}, {31'd0, bus.out_halted}, {31'd0, halt});
        chk({tag, ".cycles"}, bus.out_cycles, STATS ? cyc : 32'd0);
        chk({tag, ".uncond"}, bus.out_uncond, STATS ? unc : 32'd0);
        chk({tag, ".cond"}, bus.out_cond, STATS ? cnd : 32'd0);
    endtask

    initial begin
        vec_t h;
        checks   = 0;
        failures = 0;

        //   rst  instr          strobes          eq  rs            v0     go    pc            halt cyc  unc cnd
        add(1'b1, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h0,        0,  0,   0,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h4,        0,  1,   0,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h8,        0,  2,   0,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'hC,        0,  3,   0,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h10,       0,  4,   0,  0);
        add(1'b0, 32'h0000FFFE,  S_BEQ,           1, 32'h0,        32'd0, 1'b0, 32'hC,        0,  5,   0,  1);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h10,       0,  6,   0,  1);
        add(1'b0, 32'h0000FFFE,  S_BEQ,           0, 32'h0,        32'd0, 1'b0, 32'h14,       0,  7,   0,  1);
        add(1'b0, 32'h00000002,  S_BNE,           0, 32'h0,        32'd0, 1'b0, 32'h20,       0,  8,   0,  2);
        add(1'b0, 32'h00000040,  S_JR | S_J,      0, 32'h400,      32'd0, 1'b0, 32'h400,      0,  9,   1,  2);
        add(1'b0, 32'h00000004,  S_BGEZ,          0, 32'h80000000, 32'd0, 1'b0, 32'h404,      0,  10,  1,  2);
        add(1'b0, 32'h00000004,  S_BGEZ,          0, 32'h5,        32'd0, 1'b0, 32'h418,      0,  11,  1,  3);
        add(1'b0, 32'h0000000C,  S_J | S_BEQ,     1, 32'h0,        32'd0, 1'b0, 32'h30,       0,  12,  2,  3);
        add(1'b0, 32'h0,         S_SYS,           0, 32'h0,        32'd10, 1'b0, 32'h30,      1,  13,  2,  3);
        for (int i = 0; i < 5; i++)
            add(1'b0, 32'h0000000C, S_J | S_BEQ,  1, 32'h0,        32'd0, 1'b0, 32'h30,       1,  13,  2,  3);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b1, 32'h34,       0,  13,  2,  3);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b1, 32'h38,       0,  14,  2,  3);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b1, 32'h3C,       0,  15,  2,  3);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b1, 32'h40,       0,  16,  2,  3);
        add(1'b0, 32'h0,         S_SYS,           0, 32'h0,        32'd1, 1'b0, 32'h44,       0,  17,  2,  3);
        add(1'b0, 32'h0,         S_SYS,           0, 32'h0,        32'd10, 1'b1, 32'h44,      1,  18,  2,  3);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b1, 32'h44,       1,  18,  2,  3);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h44,       1,  18,  2,  3);
        add(1'b1, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h0,        0,  0,   0,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h4,        0,  1,   0,  0);
        add(1'b0, 32'h0,         S_JR,            0, 32'hFFFFFFFC, 32'd0, 1'b0, 32'hFFFFFFFC, 0,  2,   1,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b0, 32'h0,        0,  3,   1,  0);
        add(1'b0, 32'h0,         S_JR,            0, 32'h80000000, 32'd0, 1'b0, 32'h80000000, 0,  4,   2,  0);
        add(1'b0, 32'h00000040,  S_JW,            0, 32'h0,        32'd0, 1'b0, 32'h80000100, 0,  5,   3,  0);
        add(1'b0, 32'h00008000,  S_BEQ,           1, 32'h0,        32'd0, 1'b0, 32'h7FFE0104, 0,  6,   3,  1);
        add(1'b0, 32'h0,         S_SYS,           0, 32'h0,        32'd10, 1'b0, 32'h7FFE0104, 1, 7,   3,  1);
        add(1'b1, 32'h00000004,  S_BEQ,           1, 32'h0,        32'd0, 1'b1, 32'h0,        0,  0,   0,  0);
        add(1'b0, 32'h0,         S_NONE,          0, 32'h0,        32'd0, 1'b1, 32'h4,        0,  1,   0,  0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge in_clk);
            @(negedge in_clk);
            check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].halt,
                        vecs[i].cyc, vecs[i].unc, vecs[i].cnd);
        end

        // Hand sequence: go held high through reset never fires, even into HALT.
        h = '{1'b1, 32'h0, S_NONE, 1'b0, 32'h0, 32'd0, 1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 32'd0};
        drive(h);
        @(posedge in_clk);
        @(negedge in_clk);
        check_state("hs_rst", 32'h0, 1'b0, 32'd0, 32'd0, 32'd0);
        h.rst = 1'b0;
        h.stb = S_SYS;
        h.v0  = 32'd10;
        drive(h);
        @(posedge in_clk);
        @(negedge in_clk);
        check_state("hs_halt", 32'h0, 1'b1, 32'd1, 32'd0, 32'd0);
        h.stb = S_NONE;
        h.v0  = 32'd0;
        drive(h);
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        check_state("hs_go_held", 32'h0, 1'b1, 32'd1, 32'd0, 32'd0);
        h.go = 1'b0;
        drive(h);
        @(posedge in_clk);
        @(negedge in_clk);
        check_state("hs_go_low", 32'h0, 1'b1, 32'd1, 32'd0, 32'd0);
        h.go = 1'b1;
        drive(h);
        @(posedge in_clk);
        @(negedge in_clk);
        check_state("hs_resume", 32'h4, 1'b0, 32'd1, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
